// File: rtl/systolic_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// systolic_ctrl_pkg
// Shared types and default sizes for the systolic-array sequencer.
//   - sys_state_t : sequencer FSM encoding (3 bits)
//   - sys_cmd_t   : one command as issued by the main controller, sized by
//                   the package default widths
// No ports; imported by the interface, the sequencer and its decoder.
// -----------------------------------------------------------------------------
package systolic_ctrl_pkg;

  localparam int SYS_ARRAY_DIM = 4;
  localparam int SYS_ROW_W     = 8;
  localparam int SYS_ADDR_W    = 8;
  localparam int SYS_PERF_W    = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD    = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } sys_state_t;

  typedef struct packed {
    logic [SYS_ROW_W-1:0]  rows;
    logic [SYS_ADDR_W-1:0] base;
    logic                  clear;
    logic                  accumulate;
    logic                  sgn;
    logic                  transpose;
  } sys_cmd_t;

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl_if
// Command channel from the main controller into the sequencer.
//   cmd_valid / cmd_ready : handshake, transfer when both are high
//   cmd_rows              : rows to stream (0 = empty op)
//   cmd_acc_base          : first accumulator address
//   cmd_acc_clear         : clear accumulators before the run
//   cmd_accumulate        : 1 = add into accumulator, 0 = overwrite
//   cmd_signed            : signed arithmetic
//   cmd_transpose         : transpose input
// Modports: master (controller side), slave (sequencer side).
// -----------------------------------------------------------------------------
interface systolic_seq_ctrl_if
  import systolic_ctrl_pkg::*;
#(
  parameter int ROW_W  = SYS_ROW_W,
  parameter int ADDR_W = SYS_ADDR_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ROW_W-1:0]  cmd_rows;
  logic [ADDR_W-1:0] cmd_acc_base;
  logic              cmd_acc_clear;
  logic              cmd_accumulate;
  logic              cmd_signed;
  logic              cmd_transpose;

  modport master (
    output cmd_valid, cmd_rows, cmd_acc_base, cmd_acc_clear,
           cmd_accumulate, cmd_signed, cmd_transpose,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_rows, cmd_acc_base, cmd_acc_clear,
           cmd_accumulate, cmd_signed, cmd_transpose,
    output cmd_ready
  );

endinterface

// File: rtl/systolic_seq_ctrl_onehot_dec.sv
// -----------------------------------------------------------------------------
// systolic_onehot_dec
// Binary index to one-hot decoder with enable; all zeros when disabled.
//   idx_i    : binary index (IDX_W bits)
//   en_i     : decoder enable
//   onehot_o : N-bit one-hot result, bit idx_i set when en_i
// -----------------------------------------------------------------------------
module systolic_onehot_dec
  import systolic_ctrl_pkg::*;
#(
  parameter int N     = SYS_ARRAY_DIM,
  parameter int IDX_W = $clog2(SYS_ARRAY_DIM)
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N-1:0]     onehot_o
);

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign onehot_o[gi] = en_i && (idx_i == IDX_W'(gi));
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl
// Sequencer for an ARRAY_DIM x ARRAY_DIM weight-stationary systolic array.
// Accepts a command, then runs optional accumulator clear, diagonal weight
// load (ARRAY_DIM cycles), skewed compute (rows cycles) and drain
// (ARRAY_DIM cycles), emitting one accumulator write per row.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   cmd_if (slave)    : command handshake and fields
//   abort             : drop the current op, back to IDLE, no done
//   busy, done        : not-idle flag, one-cycle completion pulse
//   en_weight_pass    : weight shift enable (LOAD)
//   en_capture        : one-hot column capture strobe (LOAD)
//   row_feed_en       : request next input row (COMPUTE)
//   systolic_active   : array computing or draining
//   cfg_signed/_transpose : latched command flags
//   acc_clear         : accumulator clear pulse
//   acc_wr_en/_addr/_accum : accumulator write port
//   perf_busy_cycles, perf_ops : performance counters
//
// Build option: define SYS_PERF_CNT_EN to enable the saturating performance
// counters; otherwise the perf outputs are constant zero.
// -----------------------------------------------------------------------------
module systolic_seq_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int ARRAY_DIM = SYS_ARRAY_DIM,
  parameter int ROW_W     = SYS_ROW_W,
  parameter int ADDR_W    = SYS_ADDR_W,
  parameter int PERF_W    = SYS_PERF_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  systolic_seq_ctrl_if.slave   cmd_if,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 en_weight_pass,
  output logic [ARRAY_DIM-1:0] en_capture,
  output logic                 row_feed_en,
  output logic                 systolic_active,
  output logic                 cfg_signed,
  output logic                 cfg_transpose,
  output logic                 acc_clear,
  output logic                 acc_wr_en,
  output logic [ADDR_W-1:0]    acc_wr_addr,
  output logic                 acc_wr_accum,
  output logic [PERF_W-1:0]    perf_busy_cycles,
  output logic [PERF_W-1:0]    perf_ops
);

  localparam int IDX_W = $clog2(ARRAY_DIM);
  // One counter serves LOAD (0..N-1) and the relative COMPUTE/DRAIN count
  // (0..rows+N-1); one extra bit keeps rows+N from wrapping.
  localparam int CNT_W = ROW_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIM_C     = CNT_W'(ARRAY_DIM);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(ARRAY_DIM - 1);

  sys_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROW_W-1:0]  cfg_rows_q;
  logic              cfg_accum_q;
  logic              cfg_signed_q;
  logic              cfg_transpose_q;
  logic [ADDR_W-1:0] wr_addr_q;     // address of the next write
  logic [ADDR_W-1:0] last_addr_q;   // address of the most recent write

  logic [CNT_W-1:0]  rows_ext;
  logic              cmd_accept;
  logic              load_en;

  assign rows_ext   = {1'b0, cfg_rows_q};
  assign cmd_accept = (state_q == S_IDLE) && cmd_if.cmd_valid;

  // ---------------------------------------------------------------------------
  // Next state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    cmd_if.cmd_ready = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    acc_clear       = 1'b0;
    load_en         = 1'b0;
    row_feed_en     = 1'b0;
    systolic_active = 1'b0;
    acc_wr_en       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_if.cmd_ready = 1'b1;
        busy             = 1'b0;
        if (cmd_if.cmd_valid) begin
          cnt_d = '0;
          if (cmd_if.cmd_rows == '0)   state_d = S_DONE;
          else if (cmd_if.cmd_acc_clear) state_d = S_CLEAR;
          else                          state_d = S_LOAD;
        end
      end
      S_CLEAR: begin
        acc_clear = 1'b1;
        state_d   = S_LOAD;
        cnt_d     = '0;
      end
      S_LOAD: begin
        load_en = 1'b1;
        if (cnt_q == LOAD_LAST) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_COMPUTE: begin
        row_feed_en     = 1'b1;
        systolic_active = 1'b1;
        acc_wr_en       = (cnt_q >= DIM_C);
        cnt_d           = cnt_q + CNT_ONE;
        if (cnt_q == rows_ext - CNT_ONE) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        systolic_active = 1'b1;
        acc_wr_en       = (cnt_q >= DIM_C) && (cnt_q < rows_ext + DIM_C);
        cnt_d           = cnt_q + CNT_ONE;
        if (cnt_q == rows_ext + DIM_C - CNT_ONE) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign en_weight_pass = load_en;
  assign cfg_signed     = cfg_signed_q;
  assign cfg_transpose  = cfg_transpose_q;
  assign acc_wr_accum   = cfg_accum_q & acc_wr_en;
  // Address holds the last written value between writes.
  assign acc_wr_addr    = acc_wr_en ? wr_addr_q : last_addr_q;

  systolic_onehot_dec #(
    .N     (ARRAY_DIM),
    .IDX_W (IDX_W)
  ) u_capture_dec (
    .idx_i    (cnt_q[IDX_W-1:0]),
    .en_i     (load_en),
    .onehot_o (en_capture)
  );

  // ---------------------------------------------------------------------------
  // State, counter, latched configuration and write address
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      cfg_rows_q      <= '0;
      cfg_accum_q     <= 1'b0;
      cfg_signed_q    <= 1'b0;
      cfg_transpose_q <= 1'b0;
      wr_addr_q       <= '0;
      last_addr_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cmd_accept) begin
        cfg_rows_q      <= cmd_if.cmd_rows;
        cfg_accum_q     <= cmd_if.cmd_accumulate;
        cfg_signed_q    <= cmd_if.cmd_signed;
        cfg_transpose_q <= cmd_if.cmd_transpose;
        wr_addr_q       <= cmd_if.cmd_acc_base;
      end else if (acc_wr_en) begin
        wr_addr_q   <= wr_addr_q + ADDR_W'(1);
        last_addr_q <= wr_addr_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------------
`ifdef SYS_PERF_CNT_EN
  logic [PERF_W-1:0] perf_busy_q;
  logic [PERF_W-1:0] perf_ops_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_q <= '0;
      perf_ops_q  <= '0;
    end else begin
      if (busy && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + PERF_W'(1);
      if (done && (perf_ops_q != '1))  perf_ops_q  <= perf_ops_q + PERF_W'(1);
    end
  end

  assign perf_busy_cycles = perf_busy_q;
  assign perf_ops         = perf_ops_q;
`else
  assign perf_busy_cycles = '0;
  assign perf_ops         = '0;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_seq_ctrl
// Directed bench for systolic_seq_ctrl (ARRAY_DIM=4, ROW_W=8, ADDR_W=8).
// Cycle numbering: T is the cycle in which the command handshake happens;
// expectations for T+c are written from the timeline of a run:
//   [clear] -> N load cycles -> rows compute cycles -> N drain cycles -> done.
// -----------------------------------------------------------------------------
module tb_systolic_seq_ctrl;
  import systolic_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int RW = 8;
  localparam int AW = 8;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, en_weight_pass, row_feed_en, systolic_active;
  logic [N-1:0]  en_capture;
  logic          cfg_signed, cfg_transpose, acc_clear, acc_wr_en, acc_wr_accum;
  logic [AW-1:0] acc_wr_addr;
  logic [PW-1:0] perf_busy_cycles, perf_ops;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  systolic_seq_ctrl_if #(.ROW_W(RW), .ADDR_W(AW)) cmd_if ();

  systolic_seq_ctrl #(
    .ARRAY_DIM (N),
    .ROW_W     (RW),
    .ADDR_W    (AW),
    .PERF_W    (PW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_if           (cmd_if.slave),
    .abort            (abort),
    .busy             (busy),
    .done             (done),
    .en_weight_pass   (en_weight_pass),
    .en_capture       (en_capture),
    .row_feed_en      (row_feed_en),
    .systolic_active  (systolic_active),
    .cfg_signed       (cfg_signed),
    .cfg_transpose    (cfg_transpose),
    .acc_clear        (acc_clear),
    .acc_wr_en        (acc_wr_en),
    .acc_wr_addr      (acc_wr_addr),
    .acc_wr_accum     (acc_wr_accum),
    .perf_busy_cycles (perf_busy_cycles),
    .perf_ops         (perf_ops)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_cmd(input sys_cmd_t c);
    cmd_if.cmd_rows       = c.rows;
    cmd_if.cmd_acc_base   = c.base;
    cmd_if.cmd_acc_clear  = c.clear;
    cmd_if.cmd_accumulate = c.accumulate;
    cmd_if.cmd_signed     = c.sgn;
    cmd_if.cmd_transpose  = c.transpose;
  endtask

  // Present a command in an IDLE cycle (T) and move to T+1.
  task automatic send(input sys_cmd_t c);
    chk("ready_before_send", cmd_if.cmd_ready, 1'b1);
    put_cmd(c);
    cmd_if.cmd_valid = 1'b1;
    step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Called at T+1; checks every cycle up to and including DONE, ends at the
  // following IDLE cycle.
  task automatic expect_run(input sys_cmd_t c);
    int rows, clr, total, l0, c0, d0, w0;
    logic          e_ld, e_feed, e_act, e_wr, e_done;
    logic [N-1:0]  e_cap;
    logic [AW-1:0] e_addr;
    rows  = int'(c.rows);
    clr   = int'(c.clear);
    l0    = 1 + clr;
    c0    = l0 + N;
    d0    = c0 + rows;
    w0    = c0 + N;
    total = (rows == 0) ? 1 : d0 + N;
    for (int cy = 1; cy <= total; cy++) begin
      if (rows == 0) begin
        e_ld = 1'b0; e_feed = 1'b0; e_act = 1'b0; e_wr = 1'b0;
        e_done = (cy == 1);
      end else begin
        e_ld   = (cy >= l0) && (cy < l0 + N);
        e_feed = (cy >= c0) && (cy < d0);
        e_act  = (cy >= c0) && (cy < d0 + N);
        e_wr   = (cy >= w0) && (cy < w0 + rows);
        e_done = (cy == total);
      end
      e_cap = e_ld ? N'(1 << (cy - l0)) : '0;
      chk($sformatf("acc_clear@T+%0d", cy), acc_clear, (rows != 0) && (clr == 1) && (cy == 1));
      chk($sformatf("weight_pass@T+%0d", cy), en_weight_pass, e_ld);
      chk($sformatf("en_capture@T+%0d", cy), en_capture, e_cap);
      chk($sformatf("row_feed@T+%0d", cy), row_feed_en, e_feed);
      chk($sformatf("sys_active@T+%0d", cy), systolic_active, e_act);
      chk($sformatf("acc_wr_en@T+%0d", cy), acc_wr_en, e_wr);
      chk($sformatf("wr_accum@T+%0d", cy), acc_wr_accum, e_wr & c.accumulate);
      if (e_wr) begin
        e_addr = c.base + AW'(cy - w0);
        chk($sformatf("wr_addr@T+%0d", cy), acc_wr_addr, e_addr);
      end
      chk($sformatf("done@T+%0d", cy), done, e_done);
      chk($sformatf("busy@T+%0d", cy), busy, 1'b1);
      chk($sformatf("cmd_ready@T+%0d", cy), cmd_if.cmd_ready, 1'b0);
      chk($sformatf("cfg_signed@T+%0d", cy), cfg_signed, c.sgn);
      chk($sformatf("cfg_transpose@T+%0d", cy), cfg_transpose, c.transpose);
      step();
    end
    chk("idle_ready_after_done", cmd_if.cmd_ready, 1'b1);
    chk("idle_busy_after_done", busy, 1'b0);
    chk("idle_done_after_done", done, 1'b0);
    if (rows != 0) begin
      e_addr = c.base + AW'(rows - 1);
      chk("wr_addr_hold", acc_wr_addr, e_addr);
    end
    $display("txn rows=%0d base=0x%02h clr=%0d acc=%0d sgn=%0d tr=%0d cycles_to_done=%0d",
             rows, c.base, clr, c.accumulate, c.sgn, c.transpose, total);
  endtask

  sys_cmd_t c1, c2, c3, c4, c5, c6a, c6b, cr;

  initial begin
    cmd_if.cmd_valid = 1'b0;
    put_cmd('0);

    // ---- reset state ----
    step();
    step();
    chk("rst_ready", cmd_if.cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_capture", en_capture, '0);
    chk("rst_wr_en", acc_wr_en, 1'b0);
    chk("rst_wr_addr", acc_wr_addr, '0);
    chk("rst_cfg_signed", cfg_signed, 1'b0);
    chk("rst_perf_busy", perf_busy_cycles, '0);
    chk("rst_perf_ops", perf_ops, '0);
    rst_n = 1'b1;
    step();

    // ---- abort in IDLE is ignored ----
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_ready", cmd_if.cmd_ready, 1'b1);
    chk("idle_abort_busy", busy, 1'b0);

    // ---- 1: basic run, rows=5 base=0x10 ----
    c1 = '{rows: 8'd5, base: 8'h10, clear: 1'b0, accumulate: 1'b0, sgn: 1'b0, transpose: 1'b0};
    send(c1);
    expect_run(c1);

    // ---- 2: same with clear, accumulate, signed, transpose ----
    c2 = '{rows: 8'd5, base: 8'h10, clear: 1'b1, accumulate: 1'b1, sgn: 1'b1, transpose: 1'b1};
    send(c2);
    expect_run(c2);

    // ---- 3: address wrap FE, FF, 00, 01 ----
    c3 = '{rows: 8'd4, base: 8'hFE, clear: 1'b0, accumulate: 1'b1, sgn: 1'b0, transpose: 1'b1};
    send(c3);
    expect_run(c3);

    // ---- 4: rows=0 goes straight to DONE ----
    c4 = '{rows: 8'd0, base: 8'h55, clear: 1'b1, accumulate: 1'b0, sgn: 1'b1, transpose: 1'b0};
    send(c4);
    expect_run(c4);

    // ---- 5: abort on the 2nd COMPUTE cycle (T+6) ----
    c5 = '{rows: 8'd5, base: 8'h20, clear: 1'b0, accumulate: 1'b0, sgn: 1'b0, transpose: 1'b0};
    send(c5);
    for (int i = 0; i < 5; i++) step();
    chk("abort_in_compute_feed", row_feed_en, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_ready", cmd_if.cmd_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_feed", row_feed_en, 1'b0);
    chk("abort_active", systolic_active, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("abort_no_wr[%0d]", i), acc_wr_en, 1'b0);
      chk($sformatf("abort_no_done[%0d]", i), done, 1'b0);
      step();
    end

    // ---- asynchronous reset mid-operation ----
    cr = '{rows: 8'd3, base: 8'h00, clear: 1'b0, accumulate: 1'b1, sgn: 1'b1, transpose: 1'b1};
    send(cr);
    step();
    chk("pre_rst_weight_pass", en_weight_pass, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_ready", cmd_if.cmd_ready, 1'b1);
    chk("async_rst_weight_pass", en_weight_pass, 1'b0);
    chk("async_rst_signed", cfg_signed, 1'b0);
    chk("async_rst_done", done, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // ---- 6: cmd_valid held through DONE, back-to-back commands ----
    c6a = '{rows: 8'd2, base: 8'h30, clear: 1'b0, accumulate: 1'b0, sgn: 1'b0, transpose: 1'b0};
    c6b = '{rows: 8'd3, base: 8'h40, clear: 1'b1, accumulate: 1'b1, sgn: 1'b1, transpose: 1'b0};
    chk("b2b_ready_a", cmd_if.cmd_ready, 1'b1);
    put_cmd(c6a);
    cmd_if.cmd_valid = 1'b1;
    step();
    put_cmd(c6b);
    expect_run(c6a);
    chk("b2b_accept_b_ready", cmd_if.cmd_ready, 1'b1);
    step();
    cmd_if.cmd_valid = 1'b0;
    expect_run(c6b);
`ifdef SYS_PERF_CNT_EN
    // A: 1+4+2+4 = 11 busy cycles, B: 1+1+4+3+4 = 13 busy cycles.
    chk("perf_ops", perf_ops, 32'd2);
    chk("perf_busy_cycles", perf_busy_cycles, 32'd24);
`else
    chk("perf_ops_off", perf_ops, '0);
    chk("perf_busy_off", perf_busy_cycles, '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
